// File: rtl/vga_pkg.sv
// Shared constants and types for the 640x480@60 VGA frame-buffer reader.
// Holds default timing, line geometry and the 12-bit colour type.
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int WORDS_PER_LINE = DEF_H_VISIBLE / 32;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    localparam rgb12_t DEF_FG_COLOR = 12'hFFF;
    localparam rgb12_t DEF_BG_COLOR = 12'h000;

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with raw (undelayed) sync and
// visibility flags. Ports: clock, reset, h_cnt, v_cnt, visible, hs_raw,
// vs_raw (active low), origin (h=0,v=0), vblank (v >= V_VISIBLE).
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic       clock,
    input  logic       reset,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       visible,
    output logic       hs_raw,
    output logic       vs_raw,
    output logic       origin,
    output logic       vblank
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_RST    = 10'(H_TOTAL - 2);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEGIN = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    // Reset lands two clocks before (0,0) so the word-0 fetch of line 0
    // (rdaddress = 0 at h = H_TOTAL-2) is already in place.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt <= H_RST;
            v_cnt <= V_LAST;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    assign visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign hs_raw  = !((h_cnt >= HS_BEGIN) && (h_cnt < HS_END));
    assign vs_raw  = !((v_cnt >= VS_BEGIN) && (v_cnt < VS_END));
    assign origin  = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign vblank  = (v_cnt >= V_VIS);

endmodule

// File: rtl/vga_fetch_ctrl.sv
// 1bpp frame-buffer reader: fetches 32b words ahead of the beam, shifts
// pixels out and drives registered RGB/sync. Ports: clock, reset,
// rdaddress/q (read port, 1-cycle latency), red/green/blue, h_sync,
// v_sync, frame_start (pixel 0,0 on pins), in_vblank.
module vga_fetch_ctrl
    import vga_pkg::*;
#(
    parameter int     H_VISIBLE = DEF_H_VISIBLE,
    parameter int     H_FP      = DEF_H_FP,
    parameter int     H_SYNC    = DEF_H_SYNC,
    parameter int     H_BP      = DEF_H_BP,
    parameter int     V_VISIBLE = DEF_V_VISIBLE,
    parameter int     V_FP      = DEF_V_FP,
    parameter int     V_SYNC    = DEF_V_SYNC,
    parameter int     V_BP      = DEF_V_BP,
    parameter rgb12_t FG_COLOR  = DEF_FG_COLOR,
    parameter rgb12_t BG_COLOR  = DEF_BG_COLOR
) (
    input  logic        clock,
    input  logic        reset,
    output logic [13:0] rdaddress,
    input  logic [31:0] q,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        h_sync,
    output logic        v_sync,
    output logic        frame_start,
    output logic        in_vblank
);

    localparam int H_TOTAL    = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int LINE_WORDS = H_VISIBLE / 32;

    localparam logic [9:0]  H_LOAD   = 10'(H_TOTAL - 3);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  H_WEND   = 10'(H_VISIBLE - 32);
    localparam logic [9:0]  V_PRELST = 10'(V_VISIBLE - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [13:0] STRIDE   = 14'(LINE_WORDS);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        visible;
    logic        hs_raw;
    logic        vs_raw;
    logic        origin;
    logic        vblank;
    logic [13:0] line_base;
    logic [31:0] shreg;
    rgb12_t      color_q;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_VISIBLE (V_VISIBLE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP)
    ) u_timing (
        .clock   (clock),
        .reset   (reset),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .visible (visible),
        .hs_raw  (hs_raw),
        .vs_raw  (vs_raw),
        .origin  (origin),
        .vblank  (vblank)
    );

    logic in_line;
    logic next_line;
    logic word_step;
    logic word_cap;
    logic line_load;
    logic line_cap;

    // Words 1..N-1 of a visible line: address steps at h=32k-3 so it is
    // on the port during 32k-2; data is captured at the end of 32k-1.
    assign in_line   = (v_cnt < 10'(V_VISIBLE));
    assign word_step = in_line && (h_cnt[4:0] == 5'd29) && (h_cnt < H_WEND);
    assign word_cap  = in_line && (h_cnt[4:0] == 5'd31) && (h_cnt < H_WEND);

    // Word 0 of the next line is fetched at the tail of this line; only
    // when that next line is visible (including the wrap into line 0).
    assign next_line = (v_cnt < V_PRELST) || (v_cnt == V_LAST);
    assign line_load = next_line && (h_cnt == H_LOAD);
    assign line_cap  = next_line && (h_cnt == H_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            line_base <= '0;
            rdaddress <= '0;
        end else if (line_load) begin
            if (v_cnt == V_LAST) begin
                line_base <= '0;
                rdaddress <= '0;
            end else begin
                line_base <= line_base + STRIDE;
                rdaddress <= line_base + STRIDE;
            end
        end else if (word_step) begin
            rdaddress <= rdaddress + 14'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg <= '0;
        end else if (word_cap || line_cap) begin
            shreg <= q;
        end
    end

    // Bit 0 of each word is the leftmost pixel of its 32-pixel group.
    logic pix;
    assign pix = shreg[h_cnt[4:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            color_q     <= '0;
            h_sync      <= 1'b1;
            v_sync      <= 1'b1;
            frame_start <= 1'b0;
            in_vblank   <= 1'b1;
        end else begin
            color_q     <= visible ? (pix ? FG_COLOR : BG_COLOR) : '0;
            h_sync      <= hs_raw;
            v_sync      <= vs_raw;
            frame_start <= origin;
            in_vblank   <= vblank;
        end
    end

    assign red   = color_q.r;
    assign green = color_q.g;
    assign blue  = color_q.b;

endmodule
